sine_nco: RTL and testbench

SINE_NCO -- requirements
Module: sine_nco

---
 rtl/sine_nco_pkg.sv | 35 +++
 rtl/sine_quarter_rom.sv | 31 +++
 rtl/sine_nco.sv | 137 +++++++++++++
 tb/tb_sine_nco.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sine_nco_pkg.sv
// Shared definitions for the stereo NCO: mode encodings and the quarter-wave
// table generator, evaluated once per table entry at elaboration.
package sine_nco_pkg;

  typedef enum logic [1:0] {
    MODE_SINE     = 2'b00,
    MODE_SQUARE   = 2'b01,
    MODE_MUTE     = 2'b10,
    MODE_SINE_ALT = 2'b11
  } mode_e;

  // pi in unsigned fixed point with FRAC_W fractional bits
  localparam int          FRAC_W = 48;
  localparam logic [63:0] PI_FIX = 64'h0003_243F_6A88_85A3;

  // round(peak * sin(pi*i/(2q))) via an integer Taylor series; x <= pi/2, so
  // ten terms leave an error far below one LSB of any practical peak.
  function automatic int quarter_sine(input int peak, input int i, input int q);
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] sum;
    x    = ({64'd0, PI_FIX} * 128'(i)) / 128'(2 * q);
    x2   = (x * x) >> FRAC_W;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = ((term * x2) >> FRAC_W) / 128'((2 * n) * (2 * n + 1));
      if (n % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    return int'((sum * 128'(peak) + (128'd1 << (FRAC_W - 1))) >> FRAC_W);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table (Q+1 entries) with a single registered read port.
module sine_quarter_rom
  import sine_nco_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int PEAK   = 5461
) (
  input  logic              clk,
  input  logic [ADDR_W-2:0] addr_i,
  output logic [DATA_W-1:0] data_o
);
  localparam int Q = 1 << (ADDR_W - 2);

  logic [DATA_W-1:0] rom [Q+1];
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  for (genvar gi = 0; gi <= Q; gi++) begin : g_tbl
    assign rom[gi] = DATA_W'(quarter_sine(PEAK, gi, Q));
  end

  always_comb data_d = rom[addr_i];

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/sine_nco.sv
// Stereo sine/square NCO: phase accumulator, quarter-wave lookup and amplitude
// scaling in a three-stage pipeline; one request in flight at a time.
module sine_nco
  import sine_nco_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int PHASE_W = 24,
  parameter int AMP_W   = 8,
  parameter int PEAK    = 5461
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic                     phase_clr,
  input  logic [PHASE_W-1:0]       freq_word,
  input  logic [PHASE_W-1:0]       phase_ofs_r,
  input  logic [AMP_W-1:0]         amp,
  input  logic [1:0]               mode,
  output logic signed [DATA_W-1:0] sample_l,
  output logic signed [DATA_W-1:0] sample_r,
  output logic                     valid,
  output logic                     busy
);
  localparam int SHIFT = PHASE_W - ADDR_W;
  localparam int PW    = DATA_W + AMP_W + 1;
  localparam logic [ADDR_W-2:0]        Q_ADDR = {1'b1, {(ADDR_W-2){1'b0}}};
  localparam logic signed [DATA_W-1:0] PEAK_S = DATA_W'(PEAK);

  logic [PHASE_W-1:0]       phase_q, phase_d, base;
  logic                     accept;
  logic                     v1_q, v1_d, v2_q, v2_d, valid_q, valid_d;
  logic [ADDR_W-1:0]        idx_s1_q [2];
  logic [ADDR_W-1:0]        idx_s1_d [2];
  logic [AMP_W-1:0]         amp_s1_q, amp_s1_d, amp_s2_q, amp_s2_d;
  mode_e                    mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
  logic [1:0]               msb_s2_q, msb_s2_d;
  logic signed [DATA_W-1:0] smp_q [2];
  logic signed [DATA_W-1:0] smp_d [2];
  logic signed [DATA_W-1:0] scaled [2];

  // Channel 0 = left, channel 1 = right; each owns a table copy so both read in parallel.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [ADDR_W-2:0]        k, rom_addr;
    logic [DATA_W-1:0]        rom_data;
    logic signed [DATA_W-1:0] tbl, raw;
    logic signed [PW-1:0]     prod;

    assign k        = {1'b0, idx_s1_q[gi][ADDR_W-3:0]};
    assign rom_addr = idx_s1_q[gi][ADDR_W-2] ? Q_ADDR - k : k;

    sine_quarter_rom #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .PEAK   (PEAK)
    ) u_rom (
      .clk    (clk),
      .addr_i (rom_addr),
      .data_o (rom_data)
    );

    assign tbl = msb_s2_q[gi] ? -$signed(rom_data) : $signed(rom_data);

    always_comb begin
      case (mode_s2_q)
        MODE_SQUARE: raw = msb_s2_q[gi] ? -PEAK_S : PEAK_S;
        MODE_MUTE:   raw = '0;
        default:     raw = tbl;
      endcase
    end

    assign prod       = PW'(raw) * PW'($signed({1'b0, amp_s2_q}));
    assign scaled[gi] = DATA_W'(prod >>> AMP_W);
  end

  assign busy   = v1_q | v2_q | valid_q;
  assign accept = req & ~busy;
  assign base   = phase_clr ? '0 : phase_q;

  always_comb begin
    phase_d   = base;
    v1_d      = accept;
    idx_s1_d  = idx_s1_q;
    amp_s1_d  = amp_s1_q;
    mode_s1_d = mode_s1_q;
    if (accept) begin
      phase_d     = base + freq_word;
      idx_s1_d[0] = ADDR_W'(base >> SHIFT);
      idx_s1_d[1] = ADDR_W'(PHASE_W'(base + phase_ofs_r) >> SHIFT);
      amp_s1_d    = amp;
      mode_s1_d   = mode_e'(mode);
    end
    v2_d      = v1_q;
    amp_s2_d  = amp_s1_q;
    mode_s2_d = mode_s1_q;
    msb_s2_d  = {idx_s1_q[1][ADDR_W-1], idx_s1_q[0][ADDR_W-1]};
    valid_d   = v2_q;
    for (int i = 0; i < 2; i++) smp_d[i] = v2_q ? scaled[i] : smp_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q   <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      valid_q   <= 1'b0;
      amp_s1_q  <= '0;
      amp_s2_q  <= '0;
      mode_s1_q <= MODE_SINE;
      mode_s2_q <= MODE_SINE;
      msb_s2_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        idx_s1_q[i] <= '0;
        smp_q[i]    <= '0;
      end
    end else begin
      phase_q   <= phase_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      valid_q   <= valid_d;
      amp_s1_q  <= amp_s1_d;
      amp_s2_q  <= amp_s2_d;
      mode_s1_q <= mode_s1_d;
      mode_s2_q <= mode_s2_d;
      msb_s2_q  <= msb_s2_d;
      for (int i = 0; i < 2; i++) begin
        idx_s1_q[i] <= idx_s1_d[i];
        smp_q[i]    <= smp_d[i];
      end
    end
  end

  assign valid    = valid_q;
  assign sample_l = smp_q[0];
  assign sample_r = smp_q[1];

endmodule

// File: tb/tb_sine_nco.sv
// Directed plus randomized bench for sine_nco; a behavioural model pushes
// expected samples and valid cycles to a scoreboard checked every cycle.
module tb_sine_nco;
  localparam int  DATA_W  = 16;
  localparam int  ADDR_W  = 8;
  localparam int  PHASE_W = 24;
  localparam int  AMP_W   = 8;
  localparam int  PEAK    = 5461;
  localparam int  Q       = 1 << (ADDR_W - 2);
  localparam real PI      = 3.14159265358979323846;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     req = 1'b0;
  logic                     phase_clr = 1'b0;
  logic [PHASE_W-1:0]       freq_word = '0;
  logic [PHASE_W-1:0]       phase_ofs_r = '0;
  logic [AMP_W-1:0]         amp = '0;
  logic [1:0]               mode = '0;
  logic signed [DATA_W-1:0] sample_l, sample_r;
  logic                     valid, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sine_nco #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PHASE_W(PHASE_W), .AMP_W(AMP_W), .PEAK(PEAK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .phase_clr(phase_clr),
    .freq_word(freq_word), .phase_ofs_r(phase_ofs_r), .amp(amp), .mode(mode),
    .sample_l(sample_l), .sample_r(sample_r), .valid(valid), .busy(busy)
  );

  typedef struct {
    int due;
    int l;
    int r;
  } exp_t;

  exp_t               sb[$];
  int                 edge_n = 0;
  int                 mbusy  = 0;
  int                 hold_l = 0;
  int                 hold_r = 0;
  logic [PHASE_W-1:0] mphase = '0;
  logic [PHASE_W-1:0] mbase;
  logic               exp_v;
  exp_t               e;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int tval(input int i);
    return int'($floor(PEAK * $sin(PI * i / (2.0 * Q)) + 0.5));
  endfunction

  function automatic int model(input logic [PHASE_W-1:0] ph, input logic [AMP_W-1:0] a,
                               input logic [1:0] m);
    int idx, k, raw;
    idx = int'(ph >> (PHASE_W - ADDR_W));
    k   = idx % Q;
    case (m)
      2'b01:   raw = ph[PHASE_W-1] ? -PEAK : PEAK;
      2'b10:   raw = 0;
      default: begin
        case (idx / Q)
          0:       raw = tval(k);
          1:       raw = tval(Q - k);
          2:       raw = -tval(k);
          default: raw = -tval(Q - k);
        endcase
      end
    endcase
    return (raw * int'(a)) >>> AMP_W;
  endfunction

  // Model and scoreboard: inputs change only on negedges, so at posedge+1 they
  // still show what the DUT sampled at that edge.
  always begin
    @(posedge clk);
    #1;
    edge_n++;
    if (!rst_n) begin
      sb.delete();
      mbusy  = 0;
      mphase = '0;
      hold_l = 0;
      hold_r = 0;
    end else begin
      mbase = phase_clr ? '0 : mphase;
      if (req && mbusy == 0) begin
        e.due = edge_n + 2;
        e.l   = model(mbase, amp, mode);
        e.r   = model(mbase + phase_ofs_r, amp, mode);
        sb.push_back(e);
        mphase = mbase + freq_word;
        mbusy  = 3;
      end else begin
        mphase = mbase;
        if (mbusy > 0) mbusy--;
      end
    end
    exp_v = (sb.size() > 0) && (sb[0].due == edge_n);
    check("valid", valid, exp_v);
    if (exp_v) begin
      hold_l = sb[0].l;
      hold_r = sb[0].r;
      void'(sb.pop_front());
    end
    check("busy", busy, mbusy != 0);
    check("sample_l", sample_l, hold_l);
    check("sample_r", sample_r, hold_r);
  end

  task automatic do_req(input logic clr);
    logic got;
    repeat (2) @(negedge clk);
    req       = 1'b1;
    phase_clr = clr;
    @(negedge clk);
    req       = 1'b0;
    phase_clr = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #2;
      got = valid;
    end
    check("req_timeout", got, 1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // ramp from phase 0 at one table step per request
    freq_word = 24'h010000; phase_ofs_r = '0; amp = 8'd255; mode = 2'b00;
    do_req(1'b0); check("ramp0", sample_l, 0);
    do_req(1'b0); check("ramp1", sample_l, 133);
    do_req(1'b0);
    do_req(1'b0); check("ramp3", sample_l, 400);

    // quarter-cycle right offset at half amplitude
    pulse_clr();
    freq_word = 24'h400000; phase_ofs_r = 24'h400000; amp = 8'd128;
    do_req(1'b0); check("ofs_l0", sample_l, 0); check("ofs_r0", sample_r, 2730);
    do_req(1'b0); check("ofs_l64", sample_l, 2730);
    do_req(1'b0); check("ofs_r192", sample_r, -2731);

    // half-cycle step: sine stays at zero crossings, square alternates
    pulse_clr();
    freq_word = 24'h800000; phase_ofs_r = '0; amp = 8'd255;
    do_req(1'b0); check("half0", sample_l, 0);
    do_req(1'b0); check("half1", sample_l, 0);
    do_req(1'b0); check("half2", sample_l, 0);
    mode = 2'b01;
    pulse_clr();
    do_req(1'b0); check("sq_pos", sample_l, 5439);
    do_req(1'b0); check("sq_neg", sample_l, -5440);

    // request held high: back-to-back acceptance every fourth cycle
    mode = 2'b00; freq_word = 24'h123457; phase_ofs_r = 24'h0A0000; amp = 8'd200;
    @(negedge clk);
    req = 1'b1;
    repeat (22) @(negedge clk);
    req = 1'b0;
    repeat (6) @(negedge clk);

    // random settings, inputs and phase_clr disturbed while a sample is in flight
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      freq_word   = PHASE_W'($urandom);
      phase_ofs_r = PHASE_W'($urandom);
      amp         = AMP_W'($urandom);
      mode        = 2'($urandom);
      phase_clr   = ($urandom_range(0, 3) == 0);
      req         = 1'b1;
      @(negedge clk);
      req         = ($urandom_range(0, 1) == 1);
      phase_clr   = ($urandom_range(0, 1) == 1);
      freq_word   = PHASE_W'($urandom);
      amp         = AMP_W'($urandom);
      mode        = 2'($urandom);
      repeat ($urandom_range(1, 5)) @(negedge clk);
      req         = 1'b0;
      phase_clr   = 1'b0;
    end
    repeat (6) @(negedge clk);

    // reset one cycle after acceptance, with req held through reset
    freq_word = 24'h010000; phase_ofs_r = '0; amp = 8'd255; mode = 2'b00;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_l", sample_l, 0);
    check("rst_r", sample_r, 0);

    // phase_clr coincident with req restarts from phase 0
    do_req(1'b0);
    do_req(1'b0);
    do_req(1'b0); check("pre_clr", sample_l, tval(2) * 255 >>> 8);
    do_req(1'b1); check("clr_req", sample_l, 0);
    do_req(1'b0); check("after_clr", sample_l, 133);

    repeat (6) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
